write_arbiter: RTL and testbench
================================

WRITE_ARBITER -- requirements
Module: write_arbiter

Interface
REQ-001 Parameter NPORT, default 16, number of ingress ports; fixed at 16 in this release.
REQ-002 Parameter BLK_SHIFT, default 4, log2 of bytes per SRAM block, used for hold-off length.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  16  per-port write request; bit i held high with port i fields stable until gnt[i].
REQ-006 req_size  input  128  port i packet size at bits [8i+7:8i].
REQ-007 req_pri  input  48  port i priority at bits [3i+2:3i].
REQ-008 req_dest  input  64  port i destination port at bits [4i+3:4i].
REQ-009 stall  input  1  chain_manager back-pressure (free list exhausted); blocks new grants.
REQ-010 gnt  output  16  one-hot, one-cycle grant pulse to the accepted port.
REQ-011 wea  output  1  one-cycle write strobe to chain_manager.
REQ-012 w_size  output  8  size of the granted packet, valid when wea=1.
REQ-013 priority  output  3  priority of the granted packet, valid when wea=1.
REQ-014 dest_port  output  4  destination of the granted packet, valid when wea=1.
REQ-015 busy  output  1  high whenever state is HOLD.

Function
REQ-016 Two states: IDLE, HOLD; all outputs registered.
REQ-017 In IDLE with stall=0 and req!=0, winner is the first set req bit searching upward from rr_ptr, wrapping 15->0.
REQ-018 Request sampled in cycle N drives wea=1, gnt[winner]=1, w_size/priority/dest_port = winner fields in cycle N+1.
REQ-019 Same edge: state->HOLD, rr_ptr <- (winner+1) mod 16, hold counter loaded with H-1.
REQ-020 H = (w_size + 2^BLK_SHIFT - 1) >> BLK_SHIFT, computed at 9-bit width; w_size=0 gives H=1; max H=16.
REQ-021 HOLD lasts H cycles including the wea cycle; counter decrements each cycle; at 0 state->IDLE.
REQ-022 No arbitration sampling in HOLD; minimum spacing between wea pulses is H+1 cycles.
REQ-023 wea and gnt low in every cycle other than the issue cycle; w_size/priority/dest_port hold last granted values.
REQ-024 stall=1 in IDLE: no grant, rr_ptr unchanged; stall in HOLD has no effect on the current hold.
REQ-025 req=0 in IDLE: remain IDLE, rr_ptr unchanged.
REQ-026 Single requester port i held continuously is granted every H+1 cycles (fairness cannot starve it).
REQ-027 All 16 requesting: grants in order rr_ptr, rr_ptr+1, ... mod 16; each port once per 16 grants.
REQ-028 req bit dropped before grant is never granted; no latching of requests.

Reset
REQ-029 rst=1 at a rising edge: state IDLE, rr_ptr=0, hold counter=0, gnt=0, wea=0, busy=0, w_size=0, priority=0, dest_port=0.
REQ-030 rst mid-HOLD aborts the hold; first grant possible from request sampled in the first cycle after rst deasserts.
REQ-031 rst dominates stall and req.

Verification
REQ-032 Reset, req=0x0001, size0=60, pri0=0, dest0=0 -> next cycle wea=1, gnt=0x0001, w_size=60; busy 4 cycles; next wea 5 cycles after first.
REQ-033 req=0xFFFF, all sizes 16, after reset -> gnt order 0x0001,0x0002,...,0x8000, then 0x0001; wea every 2 cycles.
REQ-034 req=0x8001 after port 3 granted (rr_ptr=4) -> port 15 granted before port 0.
REQ-035 stall=1 with req=0x0004 for 5 cycles -> no wea/gnt; stall=0 -> wea one cycle later, gnt=0x0004.
REQ-036 size=0 -> H=1, busy 1 cycle; size=255 -> H=16, busy 16 cycles.
REQ-037 rst asserted 3 cycles into a 16-cycle HOLD -> busy=0, rr_ptr=0 next cycle; pending req=0x0003 then grants port 0 first.

Source files
------------

// File: rtl/write_arbiter.sv
// Round-robin write arbiter: grants one ingress port at a time to chain_manager, then holds
// off further grants for one cycle per SRAM block of the granted packet.
module write_arbiter #(
    parameter int unsigned NPORT     = 16,
    parameter int unsigned BLK_SHIFT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NPORT-1:0]     req_i,
    input  logic [NPORT*8-1:0]   req_size_i,
    input  logic [NPORT*3-1:0]   req_pri_i,
    input  logic [NPORT*4-1:0]   req_dest_i,
    input  logic                 stall_i,
    output logic [NPORT-1:0]     gnt_o,
    output logic                 wea_o,
    output logic [7:0]           w_size_o,
    output logic [2:0]           priority_o,
    output logic [3:0]           dest_port_o,
    output logic                 busy_o
);

    localparam int unsigned PtrW = $clog2(NPORT);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [8:0]        hold_cnt_q, hold_cnt_d;
    logic [NPORT-1:0]  gnt_q, gnt_d;
    logic              wea_q, wea_d;
    logic [7:0]        w_size_q, w_size_d;
    logic [2:0]        pri_q, pri_d;
    logic [3:0]        dest_q, dest_d;

    logic              found;
    logic [PtrW-1:0]   winner;
    logic [PtrW-1:0]   idx;
    logic [7:0]        win_size;
    logic [8:0]        blocks;

    // First requesting port at or above rr_ptr, wrapping at the top.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr_q;
        idx    = rr_ptr_q;
        for (int unsigned i = 0; i < NPORT; i++) begin
            idx = rr_ptr_q + PtrW'(i);
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Hold length in blocks; a zero-size packet still occupies one cycle.
    always_comb begin
        win_size = req_size_i[int'(winner) * 8 +: 8];
        blocks   = ({1'b0, win_size} + 9'((1 << BLK_SHIFT) - 1)) >> BLK_SHIFT;
        if (blocks == 9'd0) begin
            blocks = 9'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = '0;
        wea_d      = 1'b0;
        w_size_d   = w_size_q;
        pri_d      = pri_q;
        dest_d     = dest_q;
        case (state_q)
            StIdle: begin
                if (!stall_i && found) begin
                    state_d    = StHold;
                    rr_ptr_d   = winner + PtrW'(1);
                    hold_cnt_d = blocks - 9'd1;
                    gnt_d      = {{(NPORT-1){1'b0}}, 1'b1} << winner;
                    wea_d      = 1'b1;
                    w_size_d   = win_size;
                    pri_d      = req_pri_i[int'(winner) * 3 +: 3];
                    dest_d     = req_dest_i[int'(winner) * 4 +: 4];
                end
            end
            StHold: begin
                if (hold_cnt_q == 9'd0) begin
                    state_d = StIdle;
                end else begin
                    hold_cnt_d = hold_cnt_q - 9'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            wea_q      <= 1'b0;
            w_size_q   <= '0;
            pri_q      <= '0;
            dest_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            wea_q      <= wea_d;
            w_size_q   <= w_size_d;
            pri_q      <= pri_d;
            dest_q     <= dest_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign wea_o       = wea_q;
    assign w_size_o    = w_size_q;
    assign priority_o  = pri_q;
    assign dest_port_o = dest_q;
    assign busy_o      = (state_q == StHold);

endmodule

// File: tb/tb_write_arbiter.sv
// Directed bench for write_arbiter: grant order, hold-off length, stall and reset behaviour.
module tb_write_arbiter;

    logic         clk;
    logic         rst;
    logic [15:0]  req;
    logic [127:0] req_size;
    logic [47:0]  req_pri;
    logic [63:0]  req_dest;
    logic         stall;
    logic [15:0]  gnt;
    logic         wea;
    logic [7:0]   w_size;
    logic [2:0]   pri;
    logic [3:0]   dest_port;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n;

    write_arbiter #(
        .NPORT     (16),
        .BLK_SHIFT (4)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .req_size_i  (req_size),
        .req_pri_i   (req_pri),
        .req_dest_i  (req_dest),
        .stall_i     (stall),
        .gnt_o       (gnt),
        .wea_o       (wea),
        .w_size_o    (w_size),
        .priority_o  (pri),
        .dest_port_o (dest_port),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input int s, input int pr, input int d);
        req_size[p*8 +: 8] = 8'(s);
        req_pri[p*3 +: 3]  = 3'(pr);
        req_dest[p*4 +: 4] = 4'(d);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req   = '0;
        stall = 1'b0;
        step();
        rst   = 1'b0;
    endtask

    // Steps until wea is seen; returns the number of edges taken, or -1 if none within budget.
    task automatic run_until_wea(output int cnt);
        cnt = -1;
        for (int i = 1; i <= 64; i++) begin
            step();
            if (wea) begin
                cnt = i;
                break;
            end
        end
    endtask

    // Counts cycles busy stays high, starting from the current cycle.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            step();
        end
    endtask

    initial begin
        rst      = 1'b1;
        req      = 16'hFFFF;
        stall    = 1'b0;
        req_size = '0;
        req_pri  = '0;
        req_dest = '0;
        for (int p = 0; p < 16; p++) set_port(p, 16, 5, 7);
        step();
        step();
        // Reset dominates pending requests.
        check_eq("rst_gnt", 32'(gnt), 0);
        check_eq("rst_wea", 32'(wea), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_fields", {13'd0, w_size, pri, dest_port}, 0);

        // Single port, size 60 -> 4-block hold, re-grant 5 cycles later.
        do_reset();
        set_port(0, 60, 0, 0);
        req = 16'h0001;
        run_until_wea(n);
        check_eq("p0_latency", 32'(n), 1);
        check_eq("p0_gnt", 32'(gnt), 32'h0001);
        check_eq("p0_wsize", 32'(w_size), 60);
        count_busy(n);
        check_eq("p0_busy_len", 32'(n), 4);
        run_until_wea(n);
        check_eq("p0_regrant", 32'(n), 1);
        check_eq("p0_regrant_gnt", 32'(gnt), 32'h0001);
        req = '0;
        count_busy(n);

        // All ports requesting, H=1: rotate 0..15 then back to 0, every 2 cycles.
        do_reset();
        for (int p = 0; p < 16; p++) set_port(p, 16, p % 8, 15 - p);
        req = 16'hFFFF;
        for (int k = 0; k < 17; k++) begin
            run_until_wea(n);
            check_eq($sformatf("rr_space_%0d", k), 32'(n), (k == 0) ? 1 : 2);
            check_eq($sformatf("rr_gnt_%0d", k), 32'(gnt), 32'(1) << (k % 16));
            check_eq($sformatf("rr_pri_%0d", k), 32'(pri), 32'(k % 8));
            check_eq($sformatf("rr_dest_%0d", k), 32'(dest_port), 32'(15 - (k % 16)));
        end
        req = '0;
        count_busy(n);

        // After port 3 wins, port 15 beats port 0.
        do_reset();
        req = 16'h0008;
        run_until_wea(n);
        check_eq("p3_gnt", 32'(gnt), 32'h0008);
        req = '0;
        count_busy(n);
        req = 16'h8001;
        run_until_wea(n);
        check_eq("wrap_first", 32'(gnt), 32'h8000);
        req = 16'h0001;
        run_until_wea(n);
        check_eq("wrap_second", 32'(gnt), 32'h0001);
        check_eq("wrap_space", 32'(n), 2);
        req = '0;
        count_busy(n);

        // Stall blocks grants; release grants one cycle later. Size 0 -> 1-cycle hold.
        do_reset();
        set_port(2, 0, 3, 9);
        stall = 1'b1;
        req   = 16'h0004;
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq($sformatf("stall_%0d", k), {15'd0, wea, gnt}, 0);
        end
        stall = 1'b0;
        step();
        check_eq("unstall_wea", 32'(wea), 1);
        check_eq("unstall_gnt", 32'(gnt), 32'h0004);
        check_eq("unstall_fields", {13'd0, w_size, pri, dest_port}, {13'd0, 8'd0, 3'd3, 4'd9});
        req = '0;
        count_busy(n);
        check_eq("size0_busy", 32'(n), 1);
        step();
        check_eq("hold_fields", {13'd0, w_size, pri, dest_port}, {13'd0, 8'd0, 3'd3, 4'd9});

        // Size 255 -> 16-cycle hold; stall during hold is ignored.
        set_port(2, 255, 1, 1);
        req = 16'h0004;
        run_until_wea(n);
        req   = '0;
        stall = 1'b1;
        count_busy(n);
        check_eq("size255_busy", 32'(n), 16);
        stall = 1'b0;

        // Reset three cycles into a 16-cycle hold on port 0; rr_ptr must restart at 0.
        do_reset();
        set_port(0, 255, 0, 0);
        req = 16'h0001;
        run_until_wea(n);
        check_eq("abort_gnt", 32'(gnt), 32'h0001);
        req = '0;
        step();
        step();
        check_eq("abort_busy_before", 32'(busy), 1);
        rst = 1'b1;
        set_port(0, 16, 0, 0);
        set_port(1, 16, 0, 0);
        req = 16'h0003;
        step();
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_outs", {7'd0, wea, gnt, w_size}, 0);
        rst = 1'b0;
        step();
        check_eq("abort_regrant_wea", 32'(wea), 1);
        check_eq("abort_regrant_gnt", 32'(gnt), 32'h0001);
        req = 16'h0002;
        run_until_wea(n);
        check_eq("abort_next_gnt", 32'(gnt), 32'h0002);
        check_eq("abort_next_space", 32'(n), 2);
        req = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
